mem_port_arbiter: RTL and testbench

- Shares the single memory port of the top-level wrapper between two requesters: requester 0 is the icp core, requester 1 is the host loader/debug port.
- Arbitrates one transaction per cycle with round-robin priority. A bounded lock lets a requester keep the port for short bursts.
- Routes read data back to the issuing requester through a latency-matched tag pipeline.
- Sits between the requesters and the wrapper's memory port (o_read_en/o_read_addr, o_write_en/o_write_addr, o_data, i_data).

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single memory port. Supports bounded lock bursts
// and routes read data back to its issuer through a tag pipeline aligned with i_data.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_LOCK     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic              i_req0_we,
    input  logic              i_req0_lock,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    input  logic              i_req1_valid,
    input  logic              i_req1_we,
    input  logic              i_req1_lock,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    output logic              o_req0_rvalid,
    output logic              o_req1_rvalid,
    output logic [DATA_W-1:0] o_req0_rdata,
    output logic [DATA_W-1:0] o_req1_rdata,
    output logic              o_read_en,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic [DATA_W-1:0] o_data,
    input  logic [DATA_W-1:0] i_data
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } lock_state_e;

    localparam int             CNT_W      = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W:0] LOCK_LIMIT = (CNT_W + 1)'(MAX_LOCK);

    lock_state_e           state_q, state_d;
    logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant0, grant1, xfer;
    logic                  owner_cont, other_waiting, grant_lock;
    logic [CNT_W:0]        cnt_next;
    logic                  sel_we;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  read_en_q, read_en_d, write_en_q, write_en_d;
    logic [ADDR_W-1:0]     read_addr_q, read_addr_d, write_addr_q, write_addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [READ_LATENCY:0] tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Grant selection: a valid lock owner wins outright, otherwise round-robin.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i_rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end else if (state_q == ST_LOCK0 && i_req0_valid) begin
            grant0 = 1'b1;
        end else if (state_q == ST_LOCK1 && i_req1_valid) begin
            grant1 = 1'b1;
        end else if (i_req0_valid && i_req1_valid) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
        end else begin
            grant0 = i_req0_valid;
            grant1 = i_req1_valid;
        end
    end

    // Lock state and round-robin pointer; the count includes the grant that opens the lock.
    always_comb begin
        state_d       = ST_IDLE;
        lock_cnt_d    = {CNT_W{1'b0}};
        last_grant_d  = last_grant_q;
        xfer          = grant0 | grant1;
        owner_cont    = (grant0 && state_q == ST_LOCK0) || (grant1 && state_q == ST_LOCK1);
        other_waiting = grant0 ? i_req1_valid : i_req0_valid;
        grant_lock    = grant0 ? i_req0_lock : i_req1_lock;
        cnt_next      = {1'b0, (owner_cont ? lock_cnt_q : {CNT_W{1'b0}})}
                      + {{CNT_W{1'b0}}, other_waiting};
        if (xfer) begin
            last_grant_d = grant1;
            if (grant_lock && (cnt_next < LOCK_LIMIT)) begin
                state_d    = grant0 ? ST_LOCK0 : ST_LOCK1;
                lock_cnt_d = cnt_next[CNT_W-1:0];
            end else begin
                state_d    = ST_IDLE;
                lock_cnt_d = {CNT_W{1'b0}};
            end
        end else begin
            state_d    = ST_IDLE;
            lock_cnt_d = {CNT_W{1'b0}};
        end
    end

    // Memory issue, tag pipeline and read-data return.
    always_comb begin
        sel_we       = grant1 ? i_req1_we    : i_req0_we;
        sel_addr     = grant1 ? i_req1_addr  : i_req0_addr;
        sel_wdata    = grant1 ? i_req1_wdata : i_req0_wdata;
        read_en_d    = xfer & ~sel_we;
        write_en_d   = xfer & sel_we;
        read_addr_d  = read_en_d  ? sel_addr  : read_addr_q;
        write_addr_d = write_en_d ? sel_addr  : write_addr_q;
        wdata_d      = write_en_d ? sel_wdata : wdata_q;
        tag_vld_d    = {tag_vld_q[READ_LATENCY-1:0], read_en_d};
        tag_id_d     = {tag_id_q[READ_LATENCY-1:0], grant1};
        rvalid0_d    = tag_vld_q[READ_LATENCY] & ~tag_id_q[READ_LATENCY];
        rvalid1_d    = tag_vld_q[READ_LATENCY] &  tag_id_q[READ_LATENCY];
        rdata0_d     = rvalid0_d ? i_data : rdata0_q;
        rdata1_d     = rvalid1_d ? i_data : rdata1_q;
    end

    // State registers; reset drops in-flight tags and releases the lock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            lock_cnt_q   <= {CNT_W{1'b0}};
            last_grant_q <= 1'b1;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            read_addr_q  <= {ADDR_W{1'b0}};
            write_addr_q <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            tag_vld_q    <= {(READ_LATENCY + 1){1'b0}};
            tag_id_q     <= {(READ_LATENCY + 1){1'b0}};
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            read_en_q    <= read_en_d;
            write_en_q   <= write_en_d;
            read_addr_q  <= read_addr_d;
            write_addr_q <= write_addr_d;
            wdata_q      <= wdata_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign o_req0_ready  = grant0;
    assign o_req1_ready  = grant1;
    assign o_req0_rvalid = rvalid0_q;
    assign o_req1_rvalid = rvalid1_q;
    assign o_req0_rdata  = rdata0_q;
    assign o_req1_rdata  = rdata1_q;
    assign o_read_en     = read_en_q;
    assign o_read_addr   = read_addr_q;
    assign o_write_en    = write_en_q;
    assign o_write_addr  = write_addr_q;
    assign o_data        = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants,
// memory operations and read returns; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_req0_valid, i_req0_we, i_req0_lock;
    logic [31:0] i_req0_addr, i_req0_wdata;
    logic        i_req1_valid, i_req1_we, i_req1_lock;
    logic [31:0] i_req1_addr, i_req1_wdata;
    logic        o_req0_ready, o_req1_ready, o_req0_rvalid, o_req1_rvalid;
    logic [31:0] o_req0_rdata, o_req1_rdata;
    logic        o_read_en, o_write_en;
    logic [31:0] o_read_addr, o_write_addr, o_data;
    logic [31:0] i_data = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .i_req0_we(i_req0_we), .i_req0_lock(i_req0_lock),
        .i_req0_addr(i_req0_addr), .i_req0_wdata(i_req0_wdata),
        .i_req1_valid(i_req1_valid), .i_req1_we(i_req1_we), .i_req1_lock(i_req1_lock),
        .i_req1_addr(i_req1_addr), .i_req1_wdata(i_req1_wdata),
        .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
        .o_req0_rvalid(o_req0_rvalid), .o_req1_rvalid(o_req1_rvalid),
        .o_req0_rdata(o_req0_rdata), .o_req1_rdata(o_req1_rdata),
        .o_read_en(o_read_en), .o_read_addr(o_read_addr),
        .o_write_en(o_write_en), .o_write_addr(o_write_addr),
        .o_data(o_data), .i_data(i_data)
    );

    typedef struct { logic v; logic we; logic lk; logic [31:0] a; logic [31:0] d; } rq_t;
    typedef struct { int cyc; int id; } g_exp_t;
    typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] data; } m_exp_t;
    typedef struct { int cyc; int id; logic [31:0] data; } r_exp_t;

    g_exp_t gq[$];
    m_exp_t mq[$];
    r_exp_t rq[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory, one cycle read latency; unwritten locations return a fixed pattern.
    logic [31:0] mem_wr [logic [31:0]];
    function automatic logic [31:0] mem_default(input logic [31:0] a);
        if (a == 32'h10) return 32'h0000_DEAD;
        return 32'hA000_0000 | a;
    endfunction
    always @(posedge clk) begin
        if (o_write_en) mem_wr[o_write_addr] = o_data;
        if (o_read_en) i_data <= mem_wr.exists(o_read_addr) ? mem_wr[o_read_addr]
                                                            : mem_default(o_read_addr);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the front of each queue.
    g_exp_t      ge;
    m_exp_t      me;
    r_exp_t      re;
    int          gid, rid;
    logic [31:0] rdat;
    always @(negedge clk) begin
        if (!o_req0_ready && !o_req1_ready) gid = -1;
        else if (o_req0_ready && o_req1_ready) gid = 2;
        else gid = o_req1_ready ? 1 : 0;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            ge = gq.pop_front();
            chk("grant_id", gid, ge.id);
        end else if (gid != -1) begin
            chk("unexpected_grant", gid, -1);
        end

        chk("strobe_exclusive", o_read_en & o_write_en, 0);
        if (o_read_en || o_write_en) begin
            if (mq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_mem_op: read_en=%0b write_en=%0b expected none",
                         o_read_en, o_write_en);
            end else begin
                me = mq.pop_front();
                chk("mem_op_cycle", cyc, me.cyc);
                chk("mem_op_we", o_write_en, me.we);
                if (me.we) begin
                    chk("write_addr", o_write_addr, me.addr);
                    chk("write_data", o_data, me.data);
                end else begin
                    chk("read_addr", o_read_addr, me.addr);
                end
            end
        end else if (mq.size() > 0 && mq[0].cyc <= cyc) begin
            me = mq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL missing_mem_op: no strobe, expected one at cycle %0d", me.cyc);
        end

        if (o_req0_rvalid && o_req1_rvalid) rid = 2;
        else if (o_req1_rvalid) rid = 1;
        else rid = o_req0_rvalid ? 0 : -1;
        rdat = o_req1_rvalid ? o_req1_rdata : o_req0_rdata;
        if (rid != -1) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", rid, -1);
            end else begin
                re = rq.pop_front();
                chk("rvalid_cycle", cyc, re.cyc);
                chk("rvalid_id", rid, re.id);
                chk("rdata", rdat, re.data);
            end
        end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
            re = rq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL missing_rvalid: rvalid low, expected id %0d at cycle %0d", re.id, re.cyc);
        end
    end

    function automatic rq_t none_r();
        return '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    endfunction
    function automatic rq_t rd_r(input logic [31:0] a);
        return '{1'b1, 1'b0, 1'b0, a, 32'h0};
    endfunction
    function automatic rq_t wr_r(input logic [31:0] a, input logic [31:0] d, input logic lk);
        return '{1'b1, 1'b1, lk, a, d};
    endfunction

    task automatic drive(input rq_t r0, input rq_t r1);
        i_req0_valid = r0.v; i_req0_we = r0.we; i_req0_lock = r0.lk;
        i_req0_addr  = r0.a; i_req0_wdata = r0.d;
        i_req1_valid = r1.v; i_req1_we = r1.we; i_req1_lock = r1.lk;
        i_req1_addr  = r1.a; i_req1_wdata = r1.d;
    endtask

    // One cycle of stimulus; eg is the hand-computed grant (-1 none), erd the read data.
    task automatic step(input rq_t r0, input rq_t r1, input int eg, input logic [31:0] erd);
        rq_t gr;
        drive(r0, r1);
        gq.push_back('{cyc, eg});
        if (eg >= 0) begin
            gr = (eg == 0) ? r0 : r1;
            mq.push_back('{cyc + 1, gr.we, gr.a, gr.d});
            if (!gr.we) rq.push_back('{cyc + 3, eg, erd});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(none_r(), none_r(), -1, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready0"}, o_req0_ready, 0);
        chk({tag, "_ready1"}, o_req1_ready, 0);
        chk({tag, "_read_en"}, o_read_en, 0);
        chk({tag, "_write_en"}, o_write_en, 0);
        chk({tag, "_read_addr"}, o_read_addr, 0);
        chk({tag, "_write_addr"}, o_write_addr, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_rvalid0"}, o_req0_rvalid, 0);
        chk({tag, "_rvalid1"}, o_req1_rvalid, 0);
        chk({tag, "_rdata0"}, o_req0_rdata, 0);
        chk({tag, "_rdata1"}, o_req1_rdata, 0);
    endtask

    initial begin
        drive(none_r(), none_r());
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        check_reset_outputs("por");

        // Contention: alternating grants starting with requester 0.
        for (int i = 0; i < 4; i++)
            step(rd_r(32'h1), rd_r(32'h2), i % 2, (i % 2 == 1) ? 32'hA000_0002 : 32'hA000_0001);

        // Single read.
        step(rd_r(32'h10), none_r(), 0, 32'h0000_DEAD);
        idle(3);

        // Idle stretch keeps last_grant = 0, so the next tie goes to requester 1.
        idle(10);
        step(rd_r(32'h3), rd_r(32'h4), 1, 32'hA000_0004);

        // Lock limit: eight locked writes by requester 0, then requester 1.
        for (int i = 0; i < 8; i++)
            step(wr_r(32'h100 + 32'(i), 32'(i), 1'b1), rd_r(32'h5), 0, 32'h0);
        step(wr_r(32'h108, 32'h8, 1'b1), rd_r(32'h5), 1, 32'hA000_0005);

        // Mixed write/read to the same address.
        step(wr_r(32'h20, 32'h55, 1'b0), rd_r(32'h20), 0, 32'h0);
        step(none_r(), rd_r(32'h20), 1, 32'h0000_0055);
        idle(4);

        // Reset one cycle after a read is accepted: its return must be dropped.
        step(rd_r(32'h10), none_r(), 0, 32'h0000_DEAD);
        i_rst = 1'b1;
        rq.delete();
        gq.push_back('{cyc, -1});
        @(posedge clk); #1;
        i_rst = 1'b0;
        check_reset_outputs("midrst");
        idle(4);
        step(rd_r(32'h6), rd_r(32'h7), 0, 32'hA000_0006);
        step(none_r(), rd_r(32'h7), 1, 32'hA000_0007);
        idle(5);

        chk("grant_queue_drained", gq.size(), 0);
        chk("mem_queue_drained", mq.size(), 0);
        chk("read_queue_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
